// File: rtl/piano_pkg.sv
// Note encoding and recorder state definitions shared by the piano player and recorder.
package piano_pkg;

    localparam int IDX_W   = 3;
    localparam int PITCH_W = 2;
    localparam int NOTE_W  = PITCH_W + IDX_W;

    localparam logic [PITCH_W-1:0] P_LOW  = 2'b01;
    localparam logic [PITCH_W-1:0] P_MID  = 2'b00;
    localparam logic [PITCH_W-1:0] P_HIGH = 2'b10;

    localparam logic [NOTE_W-1:0] NOTE_REST = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_REC   = 2'd2,
        ST_FULL  = 2'd3
    } rec_state_t;

    // Lowest pressed key wins; the undefined pitch code 11 folds to middle; rests carry middle pitch.
    function automatic logic [NOTE_W-1:0] encode_note(input logic [6:0] key,
                                                      input logic [PITCH_W-1:0] pitch);
        logic [IDX_W-1:0]   idx;
        logic [PITCH_W-1:0] p;
        idx = '0;
        for (int i = 6; i >= 0; i--) begin
            if (key[i]) idx = IDX_W'(i + 1);
        end
        p = (pitch == P_LOW || pitch == P_HIGH) ? pitch : P_MID;
        if (idx == '0) p = P_MID;
        return {p, idx};
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler emitting a one-cycle tick every PERIOD clock cycles.
module tick_gen #(
    parameter int PERIOD = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(PERIOD - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/song_recorder.sv
// Captures the played key/pitch stream as (note, duration) entries and replays them
// through a sequential read port.
module song_recorder
    import piano_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_MS = 10,
    parameter int DEPTH   = 64,
    parameter int DUR_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rec_en,
    input  logic [6:0]                 key,
    input  logic [1:0]                 pitch,
    input  logic                       rd_en,
    input  logic                       rd_rewind,
    output logic                       rd_valid,
    output logic [NOTE_W-1:0]          rd_note,
    output logic [DUR_W-1:0]           rd_dur,
    output logic                       rd_last,
    output logic [$clog2(DEPTH):0]     rec_count,
    output logic                       recording,
    output logic                       full
);

    localparam int AW       = $clog2(DEPTH);
    localparam int CW       = AW + 1;
    localparam int ENT_W    = NOTE_W + DUR_W;
    localparam int TICK_CYC = CLK_HZ / 1000 * TICK_MS;
    localparam logic [DUR_W-1:0] DUR_MAX = '1;

    logic              tick;
    rec_state_t        state;
    logic              rec_en_q;
    logic [NOTE_W-1:0] enc, samp_note, acc_note, acc_now, cur_note;
    logic [DUR_W-1:0]  dur;
    logic [AW-1:0]     rd_ptr, eff_ptr;
    logic [ENT_W-1:0]  mem [DEPTH];
    logic [ENT_W-1:0]  rd_word;
    logic              rec_rise, read_ok, rd_fire, at_last;
    logic              wr_req, wr_drop;

    tick_gen #(.PERIOD(TICK_CYC)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    // A sampled note replaces the accepted one only after matching on two consecutive ticks.
    assign enc     = encode_note(key, pitch);
    assign acc_now = (enc == samp_note) ? enc : acc_note;

    assign rec_rise = rec_en && !rec_en_q;
    assign wr_drop  = wr_req && (rec_count == CW'(DEPTH));

    // Read handshake: rd_en is a request pulse, honoured only when no session is active
    // (including one starting this cycle) and entries exist; the addressed entry appears
    // on rd_note/rd_dur with rd_valid=1 exactly one cycle later. rd_rewind zeroes the
    // pointer before any same-cycle request uses it.
    assign read_ok = !recording && (rec_count != '0) && !rec_rise;
    assign rd_fire = rd_en && read_ok;
    assign eff_ptr = rd_rewind ? '0 : rd_ptr;
    assign at_last = ({1'b0, eff_ptr} == rec_count - 1'b1);
    assign rd_word = mem[eff_ptr];

    always_comb begin
        wr_req = 1'b0;
        if (state == ST_REC) begin
            if (!rec_en)
                wr_req = (cur_note != NOTE_REST);
            else if (tick)
                wr_req = (acc_now != cur_note) || (dur == DUR_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_req && !wr_drop)
            mem[rec_count[AW-1:0]] <= {cur_note, dur};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rec_en_q  <= 1'b0;
            samp_note <= NOTE_REST;
            acc_note  <= NOTE_REST;
            cur_note  <= NOTE_REST;
            dur       <= '0;
            rec_count <= '0;
            recording <= 1'b0;
            full      <= 1'b0;
            rd_ptr    <= '0;
            rd_valid  <= 1'b0;
            rd_note   <= '0;
            rd_dur    <= '0;
            rd_last   <= 1'b0;
        end else begin
            rec_en_q <= rec_en;
            rd_valid <= rd_fire;

            if (tick) begin
                samp_note <= enc;
                acc_note  <= acc_now;
            end

            if (rd_fire) begin
                rd_note <= rd_word[ENT_W-1 -: NOTE_W];
                rd_dur  <= rd_word[DUR_W-1:0];
                rd_last <= at_last;
                rd_ptr  <= at_last ? '0 : eff_ptr + 1'b1;
            end else if (rd_rewind) begin
                rd_ptr <= '0;
            end

            if (wr_req) begin
                if (wr_drop) full      <= 1'b1;
                else         rec_count <= rec_count + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (rec_rise) begin
                        state     <= ST_ARMED;
                        rec_count <= '0;
                        dur       <= '0;
                        rd_ptr    <= '0;
                        recording <= 1'b1;
                        full      <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (!rec_en) begin
                        state     <= ST_IDLE;
                        recording <= 1'b0;
                    end else if (tick && acc_now != NOTE_REST) begin
                        cur_note <= acc_now;
                        dur      <= DUR_W'(1);
                        state    <= ST_REC;
                    end
                end
                ST_REC: begin
                    if (!rec_en) begin
                        state     <= ST_IDLE;
                        recording <= 1'b0;
                    end else if (tick) begin
                        if (wr_drop) begin
                            state <= ST_FULL;
                        end else if (acc_now == cur_note) begin
                            dur <= (dur == DUR_MAX) ? DUR_W'(1) : dur + 1'b1;
                        end else begin
                            cur_note <= acc_now;
                            dur      <= DUR_W'(1);
                        end
                    end
                end
                ST_FULL: begin
                    if (!rec_en) begin
                        state     <= ST_IDLE;
                        recording <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_song_recorder.sv
// Randomized and directed recording sessions checked against a run-length reference model.
`timescale 1ns/1ps
module tb_song_recorder;

    localparam int CLK_HZ  = 10_000;
    localparam int TICK_MS = 1;
    localparam int DEPTH   = 4;
    localparam int DUR_W   = 8;
    localparam int TPER    = CLK_HZ / 1000 * TICK_MS;
    localparam int ENT_W   = 5 + DUR_W;
    localparam int MAXD    = (1 << DUR_W) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       rec_en = 1'b0, rd_en = 1'b0, rd_rewind = 1'b0;
    logic [6:0] key = '0;
    logic [1:0] pitch = '0;
    logic       rd_valid, rd_last, recording, full;
    logic [4:0] rd_note;
    logic [DUR_W-1:0] rd_dur;
    logic [$clog2(DEPTH):0] rec_count;

    song_recorder #(
        .CLK_HZ(CLK_HZ), .TICK_MS(TICK_MS), .DEPTH(DEPTH), .DUR_W(DUR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rec_en(rec_en), .key(key), .pitch(pitch),
        .rd_en(rd_en), .rd_rewind(rd_rewind), .rd_valid(rd_valid), .rd_note(rd_note),
        .rd_dur(rd_dur), .rd_last(rd_last), .rec_count(rec_count),
        .recording(recording), .full(full)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [ENT_W-1:0] exp_q[$];
    logic [6:0] seg_k[$];
    logic [1:0] seg_p[$];
    int         seg_t[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [4:0] model_note(input logic [6:0] k, input logic [1:0] p);
        int idx = 0;
        for (int i = 0; i < 7; i++)
            if (k[i] && idx == 0) idx = i + 1;
        if (idx == 0) return 5'd0;
        return {(p == 2'b11) ? 2'b00 : p, 3'(idx)};
    endfunction

    // Filter the per-tick samples, run-length encode, trim rests at both ends, chunk by MAXD.
    task automatic build_expect();
        logic [4:0] prev = 5'd0, acc = 5'd0, s;
        int run_v[$];
        int run_l[$];
        int first, last, len;
        exp_q.delete();
        for (int g = 0; g < seg_k.size(); g++) begin
            for (int t = 0; t < seg_t[g]; t++) begin
                s = model_note(seg_k[g], seg_p[g]);
                if (s == prev) acc = s;
                prev = s;
                if (run_v.size() > 0 && run_v[run_v.size()-1] == int'(acc))
                    run_l[run_l.size()-1] = run_l[run_l.size()-1] + 1;
                else begin
                    run_v.push_back(int'(acc));
                    run_l.push_back(1);
                end
            end
        end
        first = 0;
        while (first < run_v.size() && run_v[first] == 0) first++;
        last = run_v.size() - 1;
        if (last >= first && run_v[last] == 0) last--;
        for (int r = first; r <= last; r++) begin
            len = run_l[r];
            while (len > MAXD) begin
                exp_q.push_back({5'(run_v[r]), DUR_W'(MAXD)});
                len -= MAXD;
            end
            exp_q.push_back({5'(run_v[r]), DUR_W'(len)});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_segs();
        seg_k.delete(); seg_p.delete(); seg_t.delete();
    endtask

    task automatic add_seg(input logic [6:0] k, input logic [1:0] p, input int t);
        seg_k.push_back(k); seg_p.push_back(p); seg_t.push_back(t);
    endtask

    task automatic do_read(input logic rew, output logic [ENT_W-1:0] ent,
                           output logic last, output logic vld);
        rd_en = 1'b1; rd_rewind = rew;
        @(negedge clk);
        rd_en = 1'b0; rd_rewind = 1'b0;
        vld = rd_valid; ent = {rd_note, rd_dur}; last = rd_last;
    endtask

    task automatic run_session(input string name, input bit rd_collide);
        int c = 0;
        int n_exp, cnt_exp;
        logic [ENT_W-1:0] ent;
        logic last, vld;
        build_expect();
        n_exp   = exp_q.size();
        cnt_exp = (n_exp > DEPTH) ? DEPTH : n_exp;

        key = '0; pitch = '0;
        repeat (3 * TPER) @(negedge clk);
        rec_en = 1'b1;
        rd_en  = rd_collide;
        @(negedge clk);
        rd_en = 1'b0;
        if (rd_collide) check({name, "_rd_vs_arm"}, 32'(rd_valid), 32'd0);
        check({name, "_arm_rec"},   32'(recording), 32'd1);
        check({name, "_arm_cnt"},   32'(rec_count), 32'd0);
        check({name, "_arm_full"},  32'(full),      32'd0);

        for (int g = 0; g < seg_k.size(); g++) begin
            key = seg_k[g]; pitch = seg_p[g];
            for (int j = 0; j < seg_t[g] * TPER; j++) begin
                @(negedge clk);
                c++;
                if (c == 3) rd_en = 1'b1;
                if (c == 4) begin
                    rd_en = 1'b0;
                    check({name, "_rd_busy"}, 32'(rd_valid), 32'd0);
                end
            end
        end
        rec_en = 1'b0;
        key = '0; pitch = '0;
        repeat (2) @(negedge clk);
        check({name, "_end_rec"},  32'(recording), 32'd0);
        check({name, "_end_cnt"},  32'(rec_count), 32'(cnt_exp));
        check({name, "_end_full"}, 32'(full),      32'(n_exp > DEPTH));

        if (cnt_exp == 0) begin
            do_read(1'b0, ent, last, vld);
            check({name, "_rd_empty"}, 32'(vld), 32'd0);
        end else begin
            for (int i = 0; i < cnt_exp; i++) begin
                do_read(1'b0, ent, last, vld);
                check($sformatf("%s_rd%0d_vld", name, i), 32'(vld), 32'd1);
                check($sformatf("%s_rd%0d_ent", name, i), 32'(ent), 32'(exp_q[i]));
                check($sformatf("%s_rd%0d_last", name, i), 32'(last), 32'(i == cnt_exp - 1));
            end
            do_read(1'b0, ent, last, vld);
            check({name, "_wrap_ent"}, 32'(ent), 32'(exp_q[0]));
            check({name, "_wrap_vld"}, 32'(vld), 32'd1);
            do_read(1'b1, ent, last, vld);
            check({name, "_rewind_ent"}, 32'(ent), 32'(exp_q[0]));
            @(negedge clk);
            check({name, "_hold_vld"}, 32'(rd_valid), 32'd0);
            check({name, "_hold_ent"}, 32'({rd_note, rd_dur}), 32'(exp_q[0]));
        end
    endtask

    task automatic reset_mid_session();
        rec_en = 1'b1; key = 7'b0000001; pitch = 2'b00;
        repeat (3 * TPER) @(negedge clk);
        key = 7'b0000010;
        repeat (4 * TPER) @(negedge clk);
        check("rst_pre_cnt", 32'(rec_count), 32'd1);
        check("rst_pre_rec", 32'(recording), 32'd1);
        #2 rst_n = 1'b0; rec_en = 1'b0; key = '0;
        #1;
        check("rst_async_out",
              32'({rd_valid, rd_note, rd_dur, rd_last, rec_count, recording, full}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_after_cnt", 32'(rec_count), 32'd0);
        check("rst_after_rec", 32'(recording), 32'd0);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
        check("rst_after_rd", 32'(rd_valid), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (3) @(negedge clk);
        check("reset_out",
              32'({rd_valid, rd_note, rd_dur, rd_last, rec_count, recording, full}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        clear_segs();
        add_seg(7'b0000001, 2'b00, 5); add_seg(7'b0000010, 2'b10, 3); add_seg(7'd0, 2'b00, 3);
        run_session("basic", 1'b0);

        clear_segs();
        add_seg(7'b0000001, 2'b00, 4); add_seg(7'b0000100, 2'b00, 1);
        add_seg(7'b0000001, 2'b00, 4); add_seg(7'd0, 2'b00, 3);
        run_session("glitch", 1'b0);

        clear_segs();
        add_seg(7'b0010000, 2'b00, 300); add_seg(7'd0, 2'b00, 3);
        run_session("sat", 1'b0);

        clear_segs();
        for (int i = 0; i < 5; i++) add_seg(7'(1 << i), 2'b01, 2);
        add_seg(7'd0, 2'b00, 3);
        run_session("full", 1'b0);

        clear_segs();
        add_seg(7'b1100000, 2'b11, 3); add_seg(7'd0, 2'b00, 2); add_seg(7'b1000000, 2'b10, 2);
        run_session("collide", 1'b1);

        clear_segs();
        add_seg(7'd0, 2'b10, 4);
        run_session("rests", 1'b0);

        reset_mid_session();

        for (int s = 0; s < 10; s++) begin
            clear_segs();
            for (int g = 0; g < $urandom_range(1, 5); g++)
                add_seg(($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127)),
                        2'($urandom_range(0, 3)), $urandom_range(1, 5));
            run_session($sformatf("rnd%0d", s), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1);
    end

endmodule
